// File: rtl/processor_slave_multi.sv
// Serial slave processor: assembles RX_LEN-byte command frames from the UART
// receiver and drains a byte FIFO to the UART transmitter via txStart/txBusy.
module processor_slave_multi #(
    parameter int unsigned RX_LEN     = 1,
    parameter int unsigned FIFO_AW    = 4,
    parameter int unsigned RX_TIMEOUT = 0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                rxReady,
    input  logic [7:0]          rxData,
    input  logic                txBusy,
    output logic                txStart,
    output logic [7:0]          txData,
    output logic [7:0]          readdata,
    output logic                cmdValid,
    output logic [8*RX_LEN-1:0] cmdData,
    input  logic                newgotdata,
    input  logic [7:0]          gotdata,
    output logic [FIFO_AW:0]    fifoCount,
    output logic                fifoFull,
    output logic                overflow
);

    localparam int unsigned IDXW  = (RX_LEN > 1) ? $clog2(RX_LEN) : 1;
    localparam int unsigned TOW   = (RX_TIMEOUT > 0) ? $clog2(RX_TIMEOUT + 1) : 1;
    localparam int unsigned DEPTH = 2 ** FIFO_AW;

    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(RX_LEN - 1);
    localparam logic [TOW-1:0]   TO_LAST  = TOW'((RX_TIMEOUT > 0) ? RX_TIMEOUT - 1 : 0);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // RX frame assembler
    // ------------------------------------------------------------------
    logic [IDXW-1:0]     idx;
    logic [TOW-1:0]      tocnt;
    logic [8*RX_LEN-1:0] frame;
    logic [8*RX_LEN-1:0] frame_next;

    // Frame including the byte arriving this cycle, so cmdData is complete on the last byte
    always_comb begin
        frame_next = frame;
        frame_next[{idx, 3'b000} +: 8] = rxData;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            idx      <= '0;
            tocnt    <= '0;
            frame    <= '0;
            readdata <= '0;
            cmdValid <= 1'b0;
            cmdData  <= '0;
        end else begin
            cmdValid <= 1'b0;
            if (rxReady) begin
                frame <= frame_next;
                tocnt <= '0;
                if (idx == '0) begin
                    readdata <= rxData;
                end
                if (idx == LAST_IDX) begin
                    cmdData  <= frame_next;
                    cmdValid <= 1'b1;
                    idx      <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else if (RX_TIMEOUT != 0 && idx != '0) begin
                // Partial frame abandoned; readdata intentionally keeps its byte 0
                if (tocnt == TO_LAST) begin
                    idx   <= '0;
                    tocnt <= '0;
                end else begin
                    tocnt <= tocnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    typedef enum logic {
        S_IDLE,
        S_GAP
    } tx_state_t;

    tx_state_t          state;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wptr;
    logic [FIFO_AW-1:0] rptr;
    logic               push;
    logic               pop;

    always_comb begin
        fifoFull = (fifoCount == FULL_CNT);
        push     = newgotdata && !fifoFull;
        pop      = (state == S_IDLE) && (fifoCount != '0) && !txBusy;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= gotdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr      <= '0;
            rptr      <= '0;
            fifoCount <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (newgotdata && fifoFull) begin
                overflow <= 1'b1;
            end
            case ({push, pop})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: fifoCount <= fifoCount;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX handshake FSM: the GAP state gives txBusy a cycle to rise
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= S_IDLE;
            txStart <= 1'b0;
            txData  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        txData  <= mem[rptr];
                        txStart <= 1'b1;
                        state   <= S_GAP;
                    end else begin
                        txStart <= 1'b0;
                    end
                end
                S_GAP: begin
                    txStart <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    txStart <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
